// File: rtl/lightgun_sched.sv
// rtl/lightgun_sched.sv - two-gun light-sensor scheduler with beam tracking
module lightgun_sched #(
    parameter int PULSE_LEN = 8,
    parameter int HOLDOFF   = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE_PIX,
    input  logic       HDE,
    input  logic       VDE,
    input  logic [1:0] TRIG,
    input  logic [1:0] OFFSCREEN,
    input  logic [7:0] X0,
    input  logic [7:0] Y0,
    input  logic [7:0] X1,
    input  logic [7:0] Y1,
    output logic       SENSOR,
    output logic       SENSOR_ID,
    output logic [1:0] RELOAD,
    output logic       BUSY
);

    localparam int PW = (PULSE_LEN < 2) ? 1 : $clog2(PULSE_LEN + 1);
    localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SCAN,
        S_FIRE,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      hcnt;
    logic [7:0]      vcnt;
    logic            hde_d;
    logic            vde_d;
    logic            vde_rise;

    logic [1:0]      trig_d;
    logic [1:0]      trig_rise;
    logic [1:0]      pending;
    logic            rr_ptr;
    logic            grant;
    logic            gnt_id;
    logic [1:0]      grant_mask;

    logic [7:0]      tx;
    logic [7:0]      ty;
    logic            sel_off;
    logic            match;
    logic [PW-1:0]   pcnt;
    logic            pulse_last;
    logic [HW-1:0]   hold_cnt;
    logic            hold_last;

    // Beam position and edge detectors, advanced only on pixel enables
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hcnt  <= '0;
            vcnt  <= '0;
            hde_d <= 1'b0;
            vde_d <= 1'b0;
        end else if (CE_PIX) begin
            hde_d <= HDE;
            vde_d <= VDE;
            if (HDE) begin
                if (hcnt != 8'hFF) begin
                    hcnt <= hcnt + 8'd1;
                end
            end else begin
                hcnt <= '0;
            end
            if (!VDE) begin
                vcnt <= '0;
            end else if (hde_d && !HDE) begin
                vcnt <= vcnt + 8'd1;
            end
        end
    end

    // Frame start, target match, arbitration choice and pulse/holdoff terminal counts
    always_comb begin
        vde_rise   = CE_PIX && VDE && !vde_d;
        trig_rise  = TRIG & ~trig_d;
        sel_off    = OFFSCREEN[SENSOR_ID];
        match      = CE_PIX && VDE && HDE && (vcnt == ty) && (hcnt == tx);
        gnt_id     = (&pending) ? rr_ptr : pending[1];
        grant      = (state == S_IDLE) && (|pending);
        grant_mask = 2'b00;
        if (grant) begin
            grant_mask = gnt_id ? 2'b10 : 2'b01;
        end
        pulse_last = (pcnt == PW'(1));
        hold_last  = ((hold_cnt + HW'(1)) == HW'(HOLDOFF));
    end

    // Trigger edge capture, request queue and round-robin pointer
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            trig_d    <= 2'b00;
            pending   <= 2'b00;
            rr_ptr    <= 1'b0;
            SENSOR_ID <= 1'b0;
        end else begin
            trig_d  <= TRIG;
            pending <= (pending & ~grant_mask) | trig_rise;
            if (grant) begin
                SENSOR_ID <= gnt_id;
                if (&pending) begin
                    rr_ptr <= ~rr_ptr;
                end
            end
        end
    end

    // Shot datapath: target latch, pulse timer, holdoff counter, sensor and reload outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx       <= '0;
            ty       <= '0;
            pcnt     <= '0;
            hold_cnt <= '0;
            SENSOR   <= 1'b0;
            RELOAD   <= 2'b00;
        end else begin
            RELOAD <= 2'b00;
            if (state == S_ARM && vde_rise) begin
                tx <= SENSOR_ID ? X1 : X0;
                ty <= SENSOR_ID ? Y1 : Y0;
                if (sel_off) begin
                    RELOAD <= SENSOR_ID ? 2'b10 : 2'b01;
                end
            end
            if (state == S_SCAN && match) begin
                pcnt   <= PW'(PULSE_LEN);
                SENSOR <= 1'b1;
            end else if (state == S_FIRE && CE_PIX) begin
                pcnt <= pcnt - PW'(1);
                if (pulse_last) begin
                    SENSOR <= 1'b0;
                end
            end
            if (state != S_HOLD) begin
                hold_cnt <= '0;
            end else if (vde_rise) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (vde_rise) begin
                    state_nxt = sel_off ? S_HOLD : S_SCAN;
                end
            end
            S_SCAN: begin
                if (match) begin
                    state_nxt = S_FIRE;
                end else if (!VDE) begin
                    state_nxt = S_HOLD;
                end
            end
            S_FIRE: begin
                if (CE_PIX && pulse_last) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (HOLDOFF == 0) begin
                    state_nxt = S_IDLE;
                end else if (vde_rise && hold_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        BUSY = (state != S_IDLE);
    end

endmodule

// File: tb/tb_lightgun_sched.sv
// tb/tb_lightgun_sched.sv - directed vector bench for lightgun_sched
module tb_lightgun_sched;

    localparam int HACT  = 20;
    localparam int HTOT  = 24;
    localparam int VACT  = 12;
    localparam int VTOT  = 14;
    localparam int LIMIT = 8000;
    localparam int PLEN_CLK = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       hde;
    logic       vde;
    logic [1:0] trig;
    logic [1:0] offs;
    logic [7:0] x0, y0, x1, y1;
    logic       sensor;
    logic       sensor_id;
    logic [1:0] reload;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int px, ln, cur_px, cur_ln;
    int n_pulses, len_cur, last_len, n_reload, busy_frames;
    logic [1:0] last_reload;
    bit busy_seen;
    bit sensor_prev;
    int rise_px[4];
    int rise_ln[4];
    int rise_id[4];

    typedef struct {
        logic [1:0] gun;
        logic [1:0] off;
        logic [7:0] x;
        logic [7:0] y;
        int         pulses;
        int         epx;
        int         eln;
        int         id;
        int         nrel;
        logic [1:0] rel;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    lightgun_sched #(.PULSE_LEN(8), .HOLDOFF(2)) dut (
        .CLK(clk),
        .RESET(rst),
        .CE_PIX(ce),
        .HDE(hde),
        .VDE(vde),
        .TRIG(trig),
        .OFFSCREEN(offs),
        .X0(x0),
        .Y0(y0),
        .X1(x1),
        .Y1(y1),
        .SENSOR(sensor),
        .SENSOR_ID(sensor_id),
        .RELOAD(reload),
        .BUSY(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raster generator (pixel enable every other clock) plus output monitor
    initial begin
        ce = 1'b0; hde = 1'b0; vde = 1'b0;
        px = 0; ln = VACT; cur_px = 0; cur_ln = VACT;
        n_pulses = 0; len_cur = 0; last_len = 0; n_reload = 0; busy_frames = 0;
        last_reload = 2'b00; busy_seen = 0; sensor_prev = 0;
        forever begin
            @(negedge clk);
            if (sensor && !sensor_prev) begin
                if (n_pulses < 4) begin
                    rise_px[n_pulses] = cur_px;
                    rise_ln[n_pulses] = cur_ln;
                    rise_id[n_pulses] = int'(sensor_id);
                end
                n_pulses++;
                len_cur = 0;
            end
            if (sensor) len_cur++;
            if (!sensor && sensor_prev) last_len = len_cur;
            sensor_prev = sensor;
            if (reload != 2'b00) begin
                n_reload++;
                last_reload = reload;
            end
            if (busy) busy_seen = 1;
            if (ce && cur_px == 0 && cur_ln == 0 && busy) busy_frames++;
            ce = !ce;
            if (ce) begin
                cur_px = px;
                cur_ln = ln;
                hde = (px < HACT);
                vde = (ln < VACT);
                px++;
                if (px == HTOT) begin
                    px = 0;
                    ln = (ln + 1) % VTOT;
                end
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1;
        n_pulses = 0; n_reload = 0; last_reload = 2'b00;
        busy_frames = 0; busy_seen = 0; last_len = 0;
    endtask

    task automatic wait_line(input int target, input string name);
        int cnt = 0;
        @(posedge clk); #1;
        while (cur_ln != target && cnt < LIMIT) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_line_timeout"}, cnt < LIMIT, 1);
    endtask

    task automatic press(input logic [1:0] mask);
        @(posedge clk); #1;
        trig = trig | mask;
        repeat (3) @(posedge clk);
        #1;
        trig = trig & ~mask;
    endtask

    task automatic wait_idle(input string name);
        int cnt = 0;
        int low = 0;
        while (low < 8 && cnt < LIMIT) begin
            @(posedge clk); #1;
            cnt++;
            if (!busy) low++;
            else low = 0;
        end
        check({name, "_idle_timeout"}, cnt < LIMIT, 1);
    endtask

    task automatic wait_sensor(input string name);
        int cnt = 0;
        @(posedge clk); #1;
        while (!sensor && cnt < LIMIT) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_sensor_timeout"}, cnt < LIMIT, 1);
    endtask

    initial begin
        vecs[0] = '{2'b01, 2'b10, 8'd5,   8'd3,  1, 5,  3,  0, 0, 2'b00};
        vecs[1] = '{2'b10, 2'b00, 8'd17,  8'd10, 1, 17, 10, 1, 0, 2'b00};
        vecs[2] = '{2'b10, 2'b10, 8'd9,   8'd4,  0, 0,  0,  1, 1, 2'b10};
        vecs[3] = '{2'b01, 2'b00, 8'd6,   8'd20, 0, 0,  0,  0, 0, 2'b00};
        vecs[4] = '{2'b01, 2'b00, 8'd255, 8'd2,  0, 0,  0,  0, 0, 2'b00};
        vecs[5] = '{2'b10, 2'b01, 8'd19,  8'd11, 1, 19, 11, 1, 0, 2'b00};
        vecs[6] = '{2'b01, 2'b01, 8'd3,   8'd3,  0, 0,  0,  0, 1, 2'b01};
        vecs[7] = '{2'b01, 2'b00, 8'd0,   8'd1,  1, 0,  1,  0, 0, 2'b00};

        rst = 1'b1; trig = 2'b00; offs = 2'b00;
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_sensor", sensor, 0);
        check("reset_sensor_id", sensor_id, 0);
        check("reset_reload", reload, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single-shot vectors; target coordinates are scrambled after the frame-start latch
        for (int i = 0; i < 8; i++) begin
            offs = vecs[i].off;
            if (vecs[i].gun == 2'b01) begin
                x0 = vecs[i].x; y0 = vecs[i].y; x1 = 8'd7; y1 = 8'd7;
            end else begin
                x1 = vecs[i].x; y1 = vecs[i].y; x0 = 8'd7; y0 = 8'd7;
            end
            wait_line(VACT, $sformatf("v%0d_blank", i));
            clear_mon();
            press(vecs[i].gun);
            wait_line(0, $sformatf("v%0d_frame", i));
            x0 = 8'd2; y0 = 8'd7; x1 = 8'd2; y1 = 8'd7;
            wait_idle($sformatf("v%0d", i));
            check($sformatf("v%0d_pulses", i), n_pulses, vecs[i].pulses);
            if (vecs[i].pulses > 0) begin
                check($sformatf("v%0d_hit_x", i), rise_px[0], vecs[i].epx);
                check($sformatf("v%0d_hit_y", i), rise_ln[0], vecs[i].eln);
                check($sformatf("v%0d_hit_id", i), rise_id[0], vecs[i].id);
                check($sformatf("v%0d_pulse_clks", i), last_len, PLEN_CLK);
            end
            check($sformatf("v%0d_sensor_id", i), sensor_id, vecs[i].id);
            check($sformatf("v%0d_reload_cnt", i), n_reload, vecs[i].nrel);
            check($sformatf("v%0d_reload_val", i), last_reload, vecs[i].rel);
            check($sformatf("v%0d_busy_frames", i), busy_frames, 2);
        end

        // Simultaneous triggers: P1 first with rr_ptr=0, then P2 first on the next pair
        offs = 2'b00; x0 = 8'd5; y0 = 8'd3; x1 = 8'd8; y1 = 8'd6;
        for (int r = 0; r < 2; r++) begin
            wait_line(VACT, "simul_blank");
            clear_mon();
            press(2'b11);
            wait_idle("simul");
            check($sformatf("simul%0d_pulses", r), n_pulses, 2);
            check($sformatf("simul%0d_first_id", r), rise_id[0], r);
            check($sformatf("simul%0d_second_id", r), rise_id[1], 1 - r);
            check($sformatf("simul%0d_first_x", r), rise_px[0], (r == 0) ? 5 : 8);
            check($sformatf("simul%0d_second_y", r), rise_ln[1], (r == 0) ? 6 : 3);
        end

        // Held P1 trigger with P2 pressed while P1 fires
        wait_line(VACT, "held_blank");
        clear_mon();
        trig = 2'b01;
        wait_sensor("held");
        press(2'b10);
        repeat (3000) @(posedge clk);
        #1;
        trig = 2'b00;
        wait_idle("held");
        check("held_pulses", n_pulses, 2);
        check("held_first_id", rise_id[0], 0);
        check("held_second_id", rise_id[1], 1);
        check("held_first_clks", last_len, PLEN_CLK);

        // Reset in the middle of a pulse with P2 queued
        wait_line(VACT, "rst_blank");
        clear_mon();
        press(2'b01);
        wait_sensor("rst");
        trig = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        trig = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pre_sensor", sensor, 1);
        rst = 1'b1;
        #1;
        check("rst_async_sensor", sensor, 0);
        check("rst_busy", busy, 0);
        check("rst_reload", reload, 0);
        check("rst_sensor_id", sensor_id, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (1400) @(posedge clk);
        #1;
        check("rst_queue_cleared", busy_seen, 0);
        check("rst_no_pulse", n_pulses, 0);

        wait_line(VACT, "post_blank");
        clear_mon();
        press(2'b01);
        wait_idle("post");
        check("post_pulses", n_pulses, 1);
        check("post_id", rise_id[0], 0);
        check("post_hit_x", rise_px[0], 5);
        check("post_hit_y", rise_ln[0], 3);
        check("post_pulse_clks", last_len, PLEN_CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
